// File: rtl/dp_ctrl.sv
// rtl/dp_ctrl.sv - decipher controller: input buffer -> inverse AES core -> output buffer
module dp_ctrl #(
    parameter int P_MAX_BYTES = 2048
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStDp,
    input  logic [11:0]  iDpByteSize,
    input  logic [127:0] iAesKey,
    input  logic [127:0] iRdDt_DpInBuf,
    input  logic         iKeyExpDone,
    input  logic         iAesDone,
    input  logic [127:0] iPlainText,
    output logic         oDpDone,
    output logic         oDpErr,
    output logic         oRdEn_DpInBuf,
    output logic [6:0]   oRdAddr_DpInBuf,
    output logic         oStKeyExp,
    output logic         oStInvAes,
    output logic [127:0] oAesKey,
    output logic [127:0] oCpText,
    output logic         oWrEn_DpOutBuf,
    output logic [6:0]   oWrAddr_DpOutBuf,
    output logic [127:0] oWrDt_DpOutBuf,
    output logic [3:0]   oWdSel_DpOutBuf
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHK    = 4'd1,
        S_ERR    = 4'd2,
        S_KEYEXP = 4'd3,
        S_WTKEY  = 4'd4,
        S_RDIN   = 4'd5,
        S_LATCH  = 4'd6,
        S_STAES  = 4'd7,
        S_WTAES  = 4'd8,
        S_WROUT  = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    localparam logic [12:0] MAX_BYTES = 13'(P_MAX_BYTES);

    state_t        state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [11:0]   size_q, size_d;
    logic [7:0]    blk_cnt_q, blk_cnt_d;
    logic [127:0]  ct_q, ct_d;
    logic [127:0]  pt_q, pt_d;
    logic [7:0]    blk_tot;
    logic          size_bad;

    // Buffers and APB side are little-endian; the core works big-endian.
    function automatic logic [127:0] byte_rev(input logic [127:0] din);
        logic [127:0] dout;
        for (int k = 0; k < 16; k++) begin
            dout[127-8*k -: 8] = din[8*k +: 8];
        end
        return dout;
    endfunction

    assign blk_tot  = size_q[11:4];
    assign size_bad = (size_q == 12'd0) || (size_q[3:0] != 4'd0) ||
                      ({1'b0, size_q} > MAX_BYTES);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            size_q    <= '0;
            blk_cnt_q <= '0;
            ct_q      <= '0;
            pt_q      <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            size_q    <= size_d;
            blk_cnt_q <= blk_cnt_d;
            ct_q      <= ct_d;
            pt_q      <= pt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        size_d         = size_q;
        blk_cnt_d      = blk_cnt_q;
        ct_d           = ct_q;
        pt_d           = pt_q;
        oDpDone        = 1'b0;
        oDpErr         = 1'b0;
        oRdEn_DpInBuf  = 1'b0;
        oStKeyExp      = 1'b0;
        oStInvAes      = 1'b0;
        oWrEn_DpOutBuf = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStDp) begin
                    key_d     = iAesKey;
                    size_d    = iDpByteSize;
                    blk_cnt_d = 8'd0;
                    state_d   = S_CHK;
                end
            end
            S_CHK:    state_d = size_bad ? S_ERR : S_KEYEXP;
            S_ERR: begin
                oDpErr  = 1'b1;
                state_d = S_IDLE;
            end
            S_KEYEXP: begin
                oStKeyExp = 1'b1;
                state_d   = S_WTKEY;
            end
            S_WTKEY: begin
                if (iKeyExpDone) state_d = S_RDIN;
            end
            S_RDIN: begin
                oRdEn_DpInBuf = 1'b1;
                state_d       = S_LATCH;
            end
            S_LATCH: begin
                ct_d    = iRdDt_DpInBuf;
                state_d = S_STAES;
            end
            S_STAES: begin
                oStInvAes = 1'b1;
                state_d   = S_WTAES;
            end
            S_WTAES: begin
                if (iAesDone) begin
                    pt_d    = iPlainText;
                    state_d = S_WROUT;
                end
            end
            S_WROUT: begin
                oWrEn_DpOutBuf = 1'b1;
                blk_cnt_d      = blk_cnt_q + 8'd1;
                state_d        = (blk_cnt_q + 8'd1 == blk_tot) ? S_DONE : S_RDIN;
            end
            S_DONE: begin
                oDpDone = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign oRdAddr_DpInBuf  = blk_cnt_q[6:0];
    assign oWrAddr_DpOutBuf = blk_cnt_q[6:0];
    assign oAesKey          = byte_rev(key_q);
    assign oCpText          = byte_rev(ct_q);
    assign oWrDt_DpOutBuf   = byte_rev(pt_q);
    assign oWdSel_DpOutBuf  = 4'b1111;

endmodule

// File: tb/tb_dp_ctrl.sv
// tb/tb_dp_ctrl.sv - directed bench for dp_ctrl with buffer, key-expansion and core models
module tb_dp_ctrl;

    logic         iClk = 1'b0;
    logic         iRst, iStDp, iKeyExpDone, iAesDone;
    logic [11:0]  iDpByteSize;
    logic [127:0] iAesKey, iRdDt_DpInBuf, iPlainText;
    logic         oDpDone, oDpErr, oRdEn_DpInBuf, oStKeyExp, oStInvAes, oWrEn_DpOutBuf;
    logic [6:0]   oRdAddr_DpInBuf, oWrAddr_DpOutBuf;
    logic [127:0] oAesKey, oCpText, oWrDt_DpOutBuf;
    logic [3:0]   oWdSel_DpOutBuf;

    dp_ctrl #(.P_MAX_BYTES(2048)) dut (
        .iClk(iClk), .iRst(iRst), .iStDp(iStDp), .iDpByteSize(iDpByteSize),
        .iAesKey(iAesKey), .iRdDt_DpInBuf(iRdDt_DpInBuf), .iKeyExpDone(iKeyExpDone),
        .iAesDone(iAesDone), .iPlainText(iPlainText), .oDpDone(oDpDone), .oDpErr(oDpErr),
        .oRdEn_DpInBuf(oRdEn_DpInBuf), .oRdAddr_DpInBuf(oRdAddr_DpInBuf),
        .oStKeyExp(oStKeyExp), .oStInvAes(oStInvAes), .oAesKey(oAesKey), .oCpText(oCpText),
        .oWrEn_DpOutBuf(oWrEn_DpOutBuf), .oWrAddr_DpOutBuf(oWrAddr_DpOutBuf),
        .oWrDt_DpOutBuf(oWrDt_DpOutBuf), .oWdSel_DpOutBuf(oWdSel_DpOutBuf)
    );

    always #5 iClk = ~iClk;

    localparam logic [127:0] FIPS_KEY    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_KEY_BE = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_IN     = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] FIPS_CT_BE  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT    = 128'hffeeddccbbaa99887766554433221100;
    localparam int           KX_LAT      = 3;

    int n_chk = 0, n_err = 0;
    int cyc = 0, lat = 1, kx_cnt = 0, aes_cnt = 0, start_cyc = 0;
    int rd_cnt, wr_cnt, kx_starts, aes_starts, done_cnt, err_cnt;
    int last_done_cyc, err_cyc, kx_cyc, done_cyc, last_wr_cyc, last_wr_addr;
    int wr_late, rd_addr_bad, wr_addr_bad, period_bad, prev_st_cyc, consec = 0, bad;
    bit fips_mode = 0, spurious = 0, restart = 0;
    bit p_kx = 0, p_st = 0, p_done = 0, p_err = 0;
    logic [127:0] ct_seen;
    logic [127:0] inbuf [128];
    logic [127:0] outbuf [128];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; kx_starts = 0; aes_starts = 0; done_cnt = 0; err_cnt = 0;
        last_done_cyc = -10; err_cyc = -1; kx_cyc = -1; done_cyc = -1; last_wr_cyc = -1;
        last_wr_addr = -1; wr_late = 0; rd_addr_bad = 0; wr_addr_bad = 0; period_bad = 0;
        prev_st_cyc = 0; ct_seen = '0;
        for (int i = 0; i < 128; i++) outbuf[i] = 'x;
    endtask

    // One clock: sample outputs at the falling edge, then drive the models' responses.
    task automatic tick();
        @(negedge iClk);
        cyc++;
        if ((oStKeyExp && p_kx) || (oStInvAes && p_st) || (oDpDone && p_done) || (oDpErr && p_err))
            consec++;
        p_kx = oStKeyExp; p_st = oStInvAes; p_done = oDpDone; p_err = oDpErr;
        iAesDone = 1'b0;
        iKeyExpDone = 1'b0;
        if (oRdEn_DpInBuf) begin
            if (oRdAddr_DpInBuf != 7'(rd_cnt)) rd_addr_bad++;
            rd_cnt++;
            iRdDt_DpInBuf = inbuf[oRdAddr_DpInBuf];
            if (spurious) begin
                iAesDone = 1'b1;
                iPlainText = '1;
            end
        end
        if (oWrEn_DpOutBuf) begin
            if (oWrAddr_DpOutBuf != 7'(wr_cnt)) wr_addr_bad++;
            if (cyc != last_done_cyc + 1) wr_late++;
            outbuf[oWrAddr_DpOutBuf] = oWrDt_DpOutBuf;
            wr_cnt++;
            last_wr_addr = int'(oWrAddr_DpOutBuf);
            last_wr_cyc = cyc;
        end
        if (oDpDone) begin done_cnt++; done_cyc = cyc; end
        if (oDpErr)  begin err_cnt++;  err_cyc = cyc;  end
        if (kx_cnt > 0) begin
            kx_cnt--;
            if (kx_cnt == 0) iKeyExpDone = 1'b1;
        end
        if (oStKeyExp) begin kx_starts++; kx_cyc = cyc; kx_cnt = KX_LAT; end
        if (aes_cnt > 0) begin
            aes_cnt--;
            if (aes_cnt == 0) begin
                iAesDone = 1'b1;
                iPlainText = fips_mode ? FIPS_PT : ~ct_seen;
                last_done_cyc = cyc;
            end
        end
        if (restart) iStDp = (aes_cnt > 1);
        if (oStInvAes) begin
            if (aes_starts > 0 && cyc - prev_st_cyc != 4 + lat) period_bad++;
            prev_st_cyc = cyc;
            aes_starts++;
            ct_seen = oCpText;
            aes_cnt = lat;
        end
    endtask

    task automatic start_job(input logic [11:0] sz, input logic [127:0] key);
        iDpByteSize = sz;
        iAesKey = key;
        iStDp = 1'b1;
        start_cyc = cyc;
        tick();
        iStDp = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("job_timeout", 128'(n >= budget), 0);
    endtask

    task automatic check_outbuf(input string tag, input int nblk);
        bad = 0;
        for (int i = 0; i < nblk; i++) if (outbuf[i] !== ~inbuf[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {oDpDone, oDpErr, oRdEn_DpInBuf, oRdAddr_DpInBuf, oStKeyExp,
                               oStInvAes, oWrEn_DpOutBuf, oWrAddr_DpOutBuf}, 0);
        check({tag, "_key"}, oAesKey, 0);
        check({tag, "_ct"}, oCpText, 0);
        check({tag, "_wdt"}, oWrDt_DpOutBuf, 0);
    endtask

    initial begin
        logic [11:0] bad_sizes [3];
        bad_sizes[0] = 12'd0; bad_sizes[1] = 12'd20; bad_sizes[2] = 12'd2064;
        iRst = 1'b1; iStDp = 1'b0; iKeyExpDone = 1'b0; iAesDone = 1'b0;
        iDpByteSize = '0; iAesKey = '0; iRdDt_DpInBuf = '0; iPlainText = '0;
        for (int i = 0; i < 128; i++)
            inbuf[i] = {32'hc0de0000 | 32'(i), 32'h12345678 + 32'(i), ~32'(i), 32'(i) * 32'h00010001};
        clear_stats();
        tick(); tick();
        iRst = 1'b0;
        check_all_zero("reset");
        check("wdsel", oWdSel_DpOutBuf, 4'hf);

        // FIPS-197 single block
        fips_mode = 1; lat = 5;
        inbuf[0] = FIPS_IN;
        clear_stats();
        start_job(12'd16, FIPS_KEY);
        wait_end(200);
        check("fips_key", oAesKey, FIPS_KEY_BE);
        check("fips_ct", ct_seen, FIPS_CT_BE);
        check("fips_out", outbuf[0], FIPS_OUT);
        check("fips_done", done_cnt, 1);
        check("fips_kx_at", kx_cyc - start_cyc, 2);
        check("fips_done_after_wr", done_cyc - last_wr_cyc, 1);
        tick();

        // Three blocks, started in the first IDLE cycle after DONE
        fips_mode = 0; lat = 10;
        inbuf[0] = {32'hc0de0000, 32'h12345678, ~32'd0, 32'd0};
        clear_stats();
        start_job(12'd48, FIPS_KEY);
        wait_end(400);
        check("b3_kx_at", kx_cyc - start_cyc, 2);
        check("b3_kx_starts", kx_starts, 1);
        check("b3_aes_starts", aes_starts, 3);
        check("b3_rd", rd_cnt, 3);
        check("b3_wr", wr_cnt, 3);
        check("b3_rd_addr", rd_addr_bad, 0);
        check("b3_wr_addr", wr_addr_bad, 0);
        check("b3_wr_timing", wr_late, 0);
        check("b3_period", period_bad, 0);
        check("b3_done", done_cnt, 1);
        check_outbuf("b3_data", 3);

        // Illegal byte counts
        foreach (bad_sizes[j]) begin
            tick(); tick();
            clear_stats();
            start_job(bad_sizes[j], FIPS_KEY);
            wait_end(20);
            for (int k = 0; k < 6; k++) tick();
            check($sformatf("err%0d_at", bad_sizes[j]), err_cyc - start_cyc, 2);
            check($sformatf("err%0d_cnt", bad_sizes[j]), err_cnt, 1);
            check($sformatf("err%0d_activity", bad_sizes[j]), rd_cnt + kx_starts + wr_cnt + done_cnt, 0);
        end

        // Maximum size
        lat = 1;
        clear_stats();
        start_job(12'd2048, FIPS_KEY);
        wait_end(2000);
        check("max_wr", wr_cnt, 128);
        check("max_last_addr", last_wr_addr, 127);
        check("max_done", done_cnt, 1);
        check("max_wr_addr", wr_addr_bad, 0);
        check("max_period", period_bad, 0);
        check_outbuf("max_data", 128);
        tick();

        // Restart during WTAES, spurious iAesDone in RDIN, input changes after start
        lat = 10; spurious = 1; restart = 1;
        clear_stats();
        start_job(12'd48, FIPS_KEY);
        iDpByteSize = 12'd16;
        iAesKey = '1;
        wait_end(400);
        spurious = 0; restart = 0; iStDp = 1'b0;
        check("ign_aes_starts", aes_starts, 3);
        check("ign_wr", wr_cnt, 3);
        check("ign_addr", rd_addr_bad + wr_addr_bad, 0);
        check("ign_key", oAesKey, FIPS_KEY_BE);
        check("ign_done", done_cnt, 1);
        check_outbuf("ign_data", 3);
        tick();

        // Reset in WTAES of block 1 of 3
        clear_stats();
        start_job(12'd48, FIPS_KEY);
        for (int k = 0; k < 200 && aes_starts < 2; k++) tick();
        tick(); tick(); tick();
        check("rst_pre_wr", wr_cnt, 1);
        iRst = 1'b1;
        aes_cnt = 0; kx_cnt = 0;
        tick();
        iRst = 1'b0;
        check_all_zero("abort");
        for (int k = 0; k < 30; k++) tick();
        check("abort_no_wr", wr_cnt, 1);
        check("abort_no_done", done_cnt, 0);
        lat = 3;
        clear_stats();
        start_job(12'd16, FIPS_KEY);
        wait_end(200);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_rd", rd_cnt, 1);
        check("post_rst_addr", rd_addr_bad + wr_addr_bad, 0);
        check_outbuf("post_rst_data", 1);

        tick();
        check("pulse_consec", consec, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
